// File: rtl/mem_request_ctrl.sv
// Cache-side memory request controller: arbitrates icache/dcache onto one variable-latency RAM.
// Optional watchdog abort (TOUT state, sticky memerr) enabled by defining MEMCTL_TIMEOUT_EN.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module mem_request_ctrl
  import cpu_types_pkg::*;
`ifdef MEMCTL_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] BAD     = 32'hBAD1BAD1
)
`endif
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        memerr
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRD  = 3'd1,
    DWR  = 3'd2,
    IRD  = 3'd3,
    TOUT = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           ren_d, wen_d;
  logic [W-1:0]   addr_d, store_d;
  logic           last_d_q, last_d_d;
  logic           dreq, owner_active, done_i, done_d;

`ifdef MEMCTL_TIMEOUT_EN
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_d;
`else
  assign memerr = 1'b0;
`endif

  // State and RAM request registers; the request is frozen between grant and completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      last_d_q <= 1'b0;
`ifdef MEMCTL_TIMEOUT_EN
      cnt_q    <= '0;
      memerr   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ramREN   <= ren_d;
      ramWEN   <= wen_d;
      ramaddr  <= addr_d;
      ramstore <= store_d;
      last_d_q <= last_d_d;
`ifdef MEMCTL_TIMEOUT_EN
      cnt_q    <= cnt_d;
      memerr   <= err_d;
`endif
    end
  end

  // Arbitration, completion detection and cache-facing responses.
  always_comb begin
    state_d      = state_q;
    ren_d        = ramREN;
    wen_d        = ramWEN;
    addr_d       = ramaddr;
    store_d      = ramstore;
    last_d_d     = last_d_q;
    owner_active = 1'b0;
    done_i       = 1'b0;
    done_d       = 1'b0;
    iload        = '0;
    dload        = '0;
    dreq         = dREN | dWEN;
`ifdef MEMCTL_TIMEOUT_EN
    cnt_d        = '0;
    err_d        = memerr;
`endif

    unique case (state_q)
      IDLE: begin
        ren_d = 1'b0;
        wen_d = 1'b0;
        // dcache wins unless it had the previous grant and the icache is waiting
        if (dreq && !(last_d_q && iREN)) begin
          state_d  = dWEN ? DWR : DRD;
          ren_d    = ~dWEN;
          wen_d    = dWEN;
          addr_d   = daddr;
          store_d  = dstore;
          last_d_d = 1'b1;
        end else if (iREN) begin
          state_d  = IRD;
          ren_d    = 1'b1;
          wen_d    = 1'b0;
          addr_d   = iaddr;
          store_d  = '0;
          last_d_d = 1'b0;
        end
      end

      DRD, DWR, IRD: begin
        owner_active = (state_q == IRD) ? iREN : ((state_q == DWR) ? dWEN : dREN);
        if (!owner_active) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else if (ramstate == ACCESS) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          if (state_q == IRD) begin
            done_i = 1'b1;
            iload  = ramload;
          end else begin
            done_d = 1'b1;
            if (state_q == DRD) dload = ramload;
          end
        end
`ifdef MEMCTL_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = TOUT;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
`endif
      end

`ifdef MEMCTL_TIMEOUT_EN
      // last_d_q still identifies the requester that was granted
      TOUT: begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        if (last_d_q) begin
          done_d = 1'b1;
          dload  = BAD;
        end else begin
          done_i = 1'b1;
          iload  = BAD;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase

    iwait = iREN & ~done_i;
    dwait = dreq & ~done_d;
  end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed plus randomized bench for mem_request_ctrl, checked every cycle against a
// transaction-level reference model; a latency-counting RAM model sits on the far side.
module tb_mem_request_ctrl;
  import cpu_types_pkg::*;

`ifdef MEMCTL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int          TIMEOUT = 64;
  localparam logic [31:0] BAD     = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST, iREN, dREN, dWEN;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  mem_request_ctrl dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: ACCESS once the same request has been held for lat full cycles.
  logic [31:0] mem [256];
  logic [65:0] rq;
  logic [65:0] last_rq = '0;
  int          rcnt = 0;
  int          eff;
  int          lat;
  bit          ram_stuck, ram_rand, pl_en;
  ramstate_t   rand_state;
  logic [31:0] rand_load, pl_data;
  logic [7:0]  pl_addr;

  assign rq = {ramREN, ramWEN, ramaddr, ramstore};

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ramWEN && ramstate == ACCESS) mem[ramaddr[7:0]] <= ramstore;
    rcnt    <= (rq == last_rq) ? rcnt + 1 : 1;
    last_rq <= rq;
  end

  always_comb begin
    eff     = (rq == last_rq) ? rcnt : 0;
    ramload = ramREN ? mem[ramaddr[7:0]] : 32'hA5A5_5A5A;
    if (ram_rand) begin
      ramstate = rand_state;
      ramload  = rand_load;
    end else if (!(ramREN || ramWEN)) ramstate = FREE;
    else if (ram_stuck || eff < lat)  ramstate = BUSY;
    else                              ramstate = ACCESS;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int tc = 0;
  int t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d test %0d: got %h expected %h", name, cyc, tc, act, exp);
    end
  endtask

  // Reference model: phase 0 = no transaction, 1 = request outstanding, 2 = timeout cycle.
  int          m_phase, m_age;
  bit          m_who_d, m_wr, m_last_d, m_err;
  logic [31:0] m_addr, m_store;

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_who_d = 0; m_wr = 0;
    m_last_d = 0; m_err = 0; m_addr = '0; m_store = '0;
  endtask

  initial model_reset();

  always @(negedge CLK) begin
    logic dreq, still, fin, gi, gd;
    logic [31:0] ei, ed;
    int rel;
    rel = cyc - t0;
    if (RST) model_reset();
    dreq  = dREN | dWEN;
    still = (m_phase == 1) && (m_who_d ? (m_wr ? dWEN : dREN) : iREN);
    fin   = still && (ramstate == ACCESS);
    gi = 0; gd = 0; ei = '0; ed = '0;
    if (m_phase == 2) begin
      if (m_who_d) begin gd = 1; ed = BAD; end
      else begin gi = 1; ei = BAD; end
    end else if (fin) begin
      if (m_who_d) begin gd = 1; if (!m_wr) ed = ramload; end
      else begin gi = 1; ei = ramload; end
    end

    check("ramREN",   32'(ramREN),   32'(m_phase == 1 && !m_wr));
    check("ramWEN",   32'(ramWEN),   32'(m_phase == 1 && m_wr));
    check("ramaddr",  ramaddr,       m_addr);
    check("ramstore", ramstore,      m_store);
    check("iwait",    32'(iwait),    32'(iREN && !gi));
    check("dwait",    32'(dwait),    32'(dreq && !gd));
    check("iload",    iload,         ei);
    check("dload",    dload,         ed);
    check("memerr",   32'(memerr),   32'(m_err));

    // Hand-computed cycle-exact expectations for the directed scenarios.
    if (tc == 0 && RST) begin
      check("rst_ramREN", 32'(ramREN), 32'd0);
      check("rst_iwait",  32'(iwait),  32'd1);
      check("rst_memerr", 32'(memerr), 32'd0);
    end
    if (tc == 1) begin
      if (rel == 1) begin check("t1_ren_c1", 32'(ramREN), 32'd1); check("t1_addr_c1", ramaddr, 32'h40); end
      if (rel == 6) check("t1_iwait_c6", 32'(iwait), 32'd1);
      if (rel == 7) begin check("t1_iwait_c7", 32'(iwait), 32'd0); check("t1_iload_c7", iload, 32'h12345678); end
      if (rel == 8) check("t1_ren_c8", 32'(ramREN), 32'd0);
    end
    if (tc == 3) begin
      if (rel == 7) begin
        check("t3_dwait_c7", 32'(dwait), 32'd0);
        check("t3_dload_c7", dload, 32'h00001111);
        check("t3_iwait_c7", 32'(iwait), 32'd1);
      end
      if (rel == 9)  begin check("t3_ren_c9", 32'(ramREN), 32'd1); check("t3_addr_c9", ramaddr, 32'h24); end
      if (rel == 15) begin check("t3_iwait_c15", 32'(iwait), 32'd0); check("t3_iload_c15", iload, 32'hCAFEF00D); end
    end
    if (tc == 4) begin
      if (rel >= 1 && rel <= 7) begin
        check("t4_wen_hold",   32'(ramWEN), 32'd1);
        check("t4_addr_hold",  ramaddr, 32'h80);
        check("t4_store_hold", ramstore, 32'hDEADBEEF);
      end
      if (rel == 7)  begin check("t4_dwait_wr", 32'(dwait), 32'd0); check("t4_dload_wr", dload, 32'd0); end
      if (rel == 16) begin check("t4_dwait_rd", 32'(dwait), 32'd0); check("t4_dload_rd", dload, 32'hDEADBEEF); end
    end
    if (tc == 5) begin
      if (rel == 2) check("t5_iwait_c2", 32'(iwait), 32'd1);
      if (rel == 3) begin check("t5_iwait_c3", 32'(iwait), 32'd0); check("t5_ren_c3", 32'(ramREN), 32'd1); end
      if (rel == 4) check("t5_ren_c4", 32'(ramREN), 32'd0);
      if (rel == 6) begin check("t5_ren_c6", 32'(ramREN), 32'd1); check("t5_addr_c6", ramaddr, 32'h24); end
      if (rel == 12) begin check("t5_dwait_c12", 32'(dwait), 32'd0); check("t5_dload_c12", dload, 32'hCAFEF00D); end
    end
    if (tc == 6) begin
      if (rel == 64) begin check("t6_dwait_c64", 32'(dwait), 32'd1); check("t6_err_c64", 32'(memerr), 32'd0); end
      if (rel == 65) begin
        check("t6_dwait_c65", 32'(dwait),  TO_EN ? 32'd0 : 32'd1);
        check("t6_dload_c65", dload,       TO_EN ? BAD : 32'd0);
        check("t6_err_c65",   32'(memerr), 32'(TO_EN));
        check("t6_ren_c65",   32'(ramREN), TO_EN ? 32'd0 : 32'd1);
      end
      if (rel == 70) check("t6_err_sticky", 32'(memerr), 32'(TO_EN));
      if (rel == 71) begin check("t6_err_rst", 32'(memerr), 32'd0); check("t6_ren_rst", 32'(ramREN), 32'd0); end
    end

    if (!RST) begin
      case (m_phase)
        0: begin
          if (dreq && !(m_last_d && iREN)) begin
            m_phase = 1; m_who_d = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
            m_age = 0; m_last_d = 1;
          end else if (iREN) begin
            m_phase = 1; m_who_d = 0; m_wr = 0; m_addr = iaddr; m_store = '0;
            m_age = 0; m_last_d = 0;
          end
        end
        1: begin
          if (!still || fin) m_phase = 0;
          else begin
            m_age++;
            if (TO_EN && m_age >= TIMEOUT) begin m_phase = 2; m_err = 1; end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_test(input int id);
    tc = id;
    t0 = cyc;
  endtask

  task automatic to_rel(input int k);
    while (cyc - t0 < k) step();
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    step();
    pl_en = 0;
  endtask

  initial begin
    int sel;
    RST = 1; iREN = 1; iaddr = 32'h40; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    lat = 6; ram_stuck = 0; ram_rand = 0; rand_state = FREE; rand_load = '0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    preload(8'h40, 32'h12345678);
    preload(8'h10, 32'h00001111);
    preload(8'h24, 32'hCAFEF00D);
    preload(8'h80, 32'h00000000);

    // reset release with icache read pending
    begin_test(1); RST = 0;
    to_rel(8); iREN = 0;
    to_rel(10);

    // simultaneous dcache and icache reads
    begin_test(3); dREN = 1; daddr = 32'h10; iREN = 1; iaddr = 32'h24;
    to_rel(8); dREN = 0;
    to_rel(16); iREN = 0;
    to_rel(18);

    // write then read back; cache-side inputs wander during the write
    begin_test(4); dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    to_rel(3); dstore = $urandom; daddr = 32'h99;
    to_rel(8); dWEN = 0;
    to_rel(9); dREN = 1; daddr = 32'h80;
    to_rel(17); dREN = 0;
    to_rel(19);

    // icache abort, then a fresh dcache request
    begin_test(5); iREN = 1; iaddr = 32'h40;
    to_rel(3); iREN = 0;
    to_rel(5); dREN = 1; daddr = 32'h24;
    to_rel(13); dREN = 0;
    to_rel(15);

    // RAM never answers
    ram_stuck = 1;
    begin_test(6); dREN = 1; daddr = 32'h10;
    to_rel(66); dREN = 0;
    to_rel(71); RST = 1;
    to_rel(72); RST = 0; ram_stuck = 0;
    to_rel(74);

    // randomized traffic
    begin_test(9);
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0) begin
        lat = $urandom_range(0, 4);
        ram_rand = (k >= 1500) && ($urandom_range(0, 1) == 1);
      end
      RST = ($urandom_range(0, 249) == 0);
      rand_state = ramstate_t'($urandom_range(0, 3));
      rand_load = $urandom;
      if (iREN) begin
        if ($urandom_range(0, 7) == 0) iREN = 0;
        else if ($urandom_range(0, 15) == 0) iaddr = 32'($urandom_range(0, 255));
      end else if ($urandom_range(0, 2) == 0) begin
        iREN = 1; iaddr = 32'($urandom_range(0, 255));
      end
      if (dREN || dWEN) begin
        if ($urandom_range(0, 7) == 0) begin dREN = 0; dWEN = 0; end
        else if ($urandom_range(0, 15) == 0) begin daddr = 32'($urandom_range(0, 255)); dstore = $urandom; end
        else if ($urandom_range(0, 31) == 0) dWEN = ~dWEN;
      end else if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 3);
        if (sel <= 1) dREN = 1;
        else if (sel == 2) dWEN = 1;
        else begin dREN = 1; dWEN = 1; end
        daddr = 32'($urandom_range(0, 255)); dstore = $urandom;
      end
      step();
    end
    RST = 0; iREN = 0; dREN = 0; dWEN = 0; ram_rand = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
